// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring unsigned divider.
// Accepts a dividend/divisor pair on a start pulse, produces one quotient
// bit per clock and returns quotient/remainder with a one-cycle done pulse.
// A zero divisor returns all-ones quotient, remainder=dividend and raises
// div_by_zero, without running the iterative steps.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q,     state_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;
    logic [WIDTH:0]   rem_q,       rem_d;      // partial remainder R, one bit wider
    logic [WIDTH-1:0] quo_q,       quo_d;      // shifting dividend / quotient Q
    logic [WIDTH-1:0] divisor_q,   divisor_d;  // captured divisor
    logic [CNT_W-1:0] count_q,     count_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    // One restoring step: shift {R,Q} left, trial-subtract, keep on non-negative.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        quo_shift = {quo_q[WIDTH-2:0], 1'b0};
        trial     = rem_shift - {1'b0, divisor_q};
        rem_step  = rem_shift;
        quo_step  = quo_shift;
        // A negative trial (MSB set) means the divisor did not fit: restore.
        if (!trial[WIDTH]) begin
            rem_step = trial;
            quo_step = {quo_shift[WIDTH-1:1], 1'b1};
        end
    end

    // Next-state and registered-output logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        divisor_d = divisor;
                        rem_d     = '0;
                        quo_d     = dividend;
                        count_d   = '0;
                        busy_d    = 1'b1;
                        state_d   = S_CALC;
                    end else begin
                        // Zero divisor: answer immediately, skip the iteration.
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end

            S_CALC: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    quotient_d  = quo_step;
                    remainder_d = rem_step[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=4).
// Stimulus pushes the expected result of each operation into a queue; an
// independent monitor pops and compares on every done pulse.
module tb_seq_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: on each done pulse pop the oldest expectation and compare.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            check("done_single_cycle", int'(prev_done), 0);
            check("busy_with_done", int'(busy), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("quotient %0d/%0d", e.a, e.b), int'(quotient), e.q);
                check($sformatf("remainder %0d/%0d", e.a, e.b), int'(remainder), e.r);
                check($sformatf("div_by_zero %0d/%0d", e.a, e.b), int'(div_by_zero), e.dbz);
                if (e.b != 0) begin
                    check($sformatf("invariant %0d/%0d", e.a, e.b),
                          int'(quotient) * e.b + int'(remainder), e.a);
                    check($sformatf("rem_lt_div %0d/%0d", e.a, e.b),
                          int'(int'(remainder) < e.b), 1);
                end
            end
        end
        prev_done = rst_n && done;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One operation: push expectation, pulse start, measure latency and busy.
    task automatic do_op(input int a, input int b, input int q_exp, input int r_exp,
                         input int dbz_exp, input bit abuse);
        int  n;
        int  busy_n;
        bit  seen;
        exp_t e;
        e.a = a; e.b = b; e.q = q_exp; e.r = r_exp; e.dbz = dbz_exp;
        sb_q.push_back(e);
        @(negedge clk);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n <= 20) begin
            if (abuse && n == 2) begin
                start    = 1'b1;
                dividend = ~WIDTH'(a);
                divisor  = WIDTH'(b) ^ 4'h5;
            end
            if (abuse && n == 3) start = 1'b0;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check($sformatf("latency %0d/%0d", a, b), seen ? n : 0, (b == 0) ? 1 : WIDTH + 1);
        check($sformatf("busy_cycles %0d/%0d", a, b), busy_n, (b == 0) ? 0 : WIDTH);
        @(negedge clk);
    endtask

    initial begin
        int done_at[3];
        int dones;
        int n;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset, then idle with start low.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst quotient", int'(quotient), 0);
        check("rst remainder", int'(remainder), 0);
        check("rst div_by_zero", int'(div_by_zero), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle done", int'(done), 0);
        end

        // Basic divide, then results must hold while idle.
        do_op(13, 3, 4, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("hold quotient", int'(quotient), 4);
        check("hold remainder", int'(remainder), 1);
        check("hold div_by_zero", int'(div_by_zero), 0);

        // Edge values.
        do_op(15, 1, 15, 0, 0, 1'b0);
        do_op(3, 5, 0, 3, 0, 1'b0);
        do_op(0, 7, 0, 0, 0, 1'b0);
        do_op(15, 15, 1, 0, 0, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        do_op(9, 0, 15, 9, 1, 1'b0);
        do_op(8, 2, 4, 0, 0, 1'b0);

        // Start re-pulsed with different operands during CALC: ignored.
        do_op(11, 2, 5, 1, 0, 1'b1);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.a = 14; e.b = 3; e.q = 4; e.r = 2; e.dbz = 0;
            sb_q.push_back(e);
        end
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        dones    = 0;
        n        = 0;
        while (dones < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                done_at[dones] = n;
                dones++;
                if (dones == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held_start dones", dones, 3);
        if (dones == 3) begin
            check("held_start first", done_at[0], WIDTH + 1);
            check("held_start spacing1", done_at[1] - done_at[0], WIDTH + 2);
            check("held_start spacing2", done_at[2] - done_at[1], WIDTH + 2);
        end
        @(negedge clk);

        // Reset two cycles after start: abort, no done pulse.
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort quotient", int'(quotient), 0);
        check("abort remainder", int'(remainder), 0);
        check("abort div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort done", int'(done), 0);
        end

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) do_op(a, b, 15, a, 1, 1'b0);
                else        do_op(a, b, a / b, a % b, 0, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
